reciprocal_sched: RTL and testbench

Round-robin scheduler that shares a single combinational `reciprocal` unit among `N_REQ` requesters. It arbitrates valid/ready requests, registers the winning operand to drive the unit, and captures the result into a response register. The response carries the requester ID and is held under downstream backpressure. It sits between the requesting datapath blocks and the `reciprocal` instance, which it drives directly through its `o_rec_*` / `i_rec_*` ports.

---
 rtl/reciprocal_sched.sv | 179 +++++++++++++++++
 tb/tb_reciprocal_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reciprocal_sched.sv
// rtl/reciprocal_sched.sv - round-robin scheduler sharing one reciprocal unit among N_REQ requesters
module reciprocal_sched #(
  parameter int N_REQ = 4,
  parameter int DW    = 24,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ*DW-1:0]   i_req_data,
  input  logic [N_REQ-1:0]      i_req_abs,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [DW-1:0]         o_rec_data,
  output logic                  o_rec_abs,
  input  logic [DW-1:0]         i_rec_data,
  input  logic                  i_rec_sat,
  output logic                  o_rsp_valid,
  output logic [DW-1:0]         o_rsp_data,
  output logic                  o_rsp_sat,
  output logic [IDW-1:0]        o_rsp_id,
  input  logic                  i_rsp_ready,
  output logic                  o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

  logic [1:0]       state_q,    state_d;
  logic [IDW-1:0]   last_q,     last_d;
  logic [IDW-1:0]   id_q,       id_d;
  logic [DW-1:0]    rec_data_q, rec_data_d;
  logic             rec_abs_q,  rec_abs_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic             rsp_sat_q,  rsp_sat_d;
  logic [IDW-1:0]   rsp_id_q,   rsp_id_d;

  logic             grant_open;
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [DW-1:0]    win_data;
  logic             win_abs;
  logic             transfer;
  int               cand;
  logic [IDW-1:0]   cand_idx;

  // A new grant may be issued when nothing is in flight or the current response is leaving.
  always_comb begin
    grant_open = (state_q == ST_IDLE) || ((state_q == ST_RESP) && i_rsp_ready);
  end

  // Round-robin search starting just after the last winner; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(last_q) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = cand[IDW-1:0];
      if (!win_found && i_req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Decode the winner to a one-hot vector and select its operand and abs flag.
  always_comb begin
    win_onehot = '0;
    win_data   = '0;
    win_abs    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_found && (win_idx == IDW'(k))) begin
        win_onehot[k] = 1'b1;
        win_data      = i_req_data[k*DW +: DW];
        win_abs       = i_req_abs[k];
      end
    end
  end

  // Grant is masked during reset so no requester believes it was accepted.
  always_comb begin
    o_req_ready = (grant_open && !reset) ? win_onehot : '0;
    transfer    = |(o_req_ready & i_req_valid);
  end

  // Control FSM: IDLE -> EXEC (one cycle) -> RESP, with RESP -> EXEC on a same-cycle grant.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = transfer ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (transfer) begin
      last_d = win_idx;
      id_d   = win_idx;
    end
  end

  // Operand register feeds the reciprocal unit and holds its value between operations.
  always_comb begin
    rec_data_d = rec_data_q;
    rec_abs_d  = rec_abs_q;
    if (transfer) begin
      rec_data_d = win_data;
      rec_abs_d  = win_abs;
    end
  end

  // Result is captured at the end of EXEC and held through RESP backpressure.
  always_comb begin
    rsp_data_d = rsp_data_q;
    rsp_sat_d  = rsp_sat_q;
    rsp_id_d   = rsp_id_q;
    if (state_q == ST_EXEC) begin
      rsp_data_d = i_rec_data;
      rsp_sat_d  = i_rec_sat;
      rsp_id_d   = id_q;
    end
  end

  // State registers; reset discards any in-flight operation and restores arbitration priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_RST;
      id_q       <= '0;
      rec_data_q <= '0;
      rec_abs_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_sat_q  <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      rec_data_q <= rec_data_d;
      rec_abs_q  <= rec_abs_d;
      rsp_data_q <= rsp_data_d;
      rsp_sat_q  <= rsp_sat_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // Output drive straight from registered state.
  always_comb begin
    o_rec_data  = rec_data_q;
    o_rec_abs   = rec_abs_q;
    o_rsp_valid = (state_q == ST_RESP);
    o_rsp_data  = rsp_data_q;
    o_rsp_sat   = rsp_sat_q;
    o_rsp_id    = rsp_id_q;
    o_busy      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_reciprocal_sched.sv
// tb/tb_reciprocal_sched.sv - directed self-checking bench for reciprocal_sched
module tb_reciprocal_sched;

  localparam int N_REQ = 4;
  localparam int DW    = 24;
  localparam int IDW   = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    rv;
  logic [DW-1:0]       rd [N_REQ];
  logic [N_REQ-1:0]    ra;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [DW-1:0]       rec_op;
  logic                rec_abs;
  logic [DW-1:0]       rec_res;
  logic                rec_sat;
  logic                rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic                rsp_sat;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_ready;
  logic                busy;
  logic [63:0]         quot;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected results of the stand-in reciprocal (1.0 = 0x400000), hand-computed.
  logic [DW-1:0] exp_res [N_REQ];
  logic          exp_sat [N_REQ];

  always #5 clk = ~clk;

  assign req_data = {rd[3], rd[2], rd[1], rd[0]};

  // Stand-in reciprocal unit: 2^44 / x, saturating to all-ones on zero or overflow.
  always_comb begin
    quot    = 64'd0;
    rec_res = '1;
    rec_sat = 1'b1;
    if (rec_op != '0) begin
      quot = (64'd1 << 44) / {40'd0, rec_op};
      if (quot <= 64'h0000_0000_00FF_FFFF) begin
        rec_res = quot[DW-1:0];
        rec_sat = 1'b0;
      end
    end
  end

  reciprocal_sched #(.N_REQ(N_REQ), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (rv),
    .i_req_data  (req_data),
    .i_req_abs   (ra),
    .o_req_ready (req_ready),
    .o_rec_data  (rec_op),
    .o_rec_abs   (rec_abs),
    .i_rec_data  (rec_res),
    .i_rec_sat   (rec_sat),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_sat   (rsp_sat),
    .o_rsp_id    (rsp_id),
    .i_rsp_ready (rsp_ready),
    .o_busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled just after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    rv        = 4'hF;
    ra        = 4'h0;
    rsp_ready = 1'b1;
    rd[0] = 24'h400000; exp_res[0] = 24'h400000; exp_sat[0] = 1'b0;
    rd[1] = 24'h200000; exp_res[1] = 24'h800000; exp_sat[1] = 1'b0;
    rd[2] = 24'h800000; exp_res[2] = 24'h200000; exp_sat[2] = 1'b0;
    rd[3] = 24'h100000; exp_res[3] = 24'hFFFFFF; exp_sat[3] = 1'b1;

    // Reset with all valids high
    @(negedge clk); #1;
    check_eq("rst_ready_0", 32'(req_ready), 32'h0);
    tick();
    check_eq("rst_ready_1", 32'(req_ready), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'h0);
    check_eq("rst_rsp_sat", 32'(rsp_sat), 32'h0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'h0);
    check_eq("rst_rec_data", 32'(rec_op), 32'h0);
    check_eq("rst_rec_abs", 32'(rec_abs), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("first_grant", 32'(req_ready), 32'h1);
    tick();
    rv = 4'h0;
    check_eq("first_exec_busy", 32'(busy), 32'h1);
    check_eq("first_rec_data", 32'(rec_op), 32'h400000);
    tick();
    check_eq("first_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("first_rsp_id", 32'(rsp_id), 32'h0);
    tick();
    check_eq("first_idle_valid", 32'(rsp_valid), 32'h0);
    check_eq("first_idle_busy", 32'(busy), 32'h0);

    // Single request from requester 2 with abs set
    rd[2] = 24'h400000;
    ra    = 4'b0100;
    rv    = 4'b0100;
    #1;
    check_eq("single_grant", 32'(req_ready), 32'h4);
    tick();
    rv = 4'h0;
    check_eq("single_rec_data", 32'(rec_op), 32'h400000);
    check_eq("single_rec_abs", 32'(rec_abs), 32'h1);
    check_eq("single_exec_valid", 32'(rsp_valid), 32'h0);
    tick();
    check_eq("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("single_rsp_id", 32'(rsp_id), 32'h2);
    check_eq("single_rsp_data", 32'(rsp_data), 32'h400000);
    check_eq("single_rsp_sat", 32'(rsp_sat), 32'h0);
    tick();
    ra = 4'h0;
    rd[2] = 24'h800000;

    // Restore priority pointer, then all four requesters hold valid
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rv = 4'hF;
    #1;
    for (int i = 0; i < 6; i++) begin
      int g;
      g = i % 4;
      check_eq($sformatf("fair_grant_%0d", i), 32'(req_ready), 32'(1 << g));
      tick();
      check_eq($sformatf("fair_exec_ready_%0d", i), 32'(req_ready), 32'h0);
      check_eq($sformatf("fair_rec_data_%0d", i), 32'(rec_op), 32'(rd[g]));
      tick();
      check_eq($sformatf("fair_rsp_valid_%0d", i), 32'(rsp_valid), 32'h1);
      check_eq($sformatf("fair_rsp_id_%0d", i), 32'(rsp_id), 32'(g));
      check_eq($sformatf("fair_rsp_data_%0d", i), 32'(rsp_data), 32'(exp_res[g]));
      check_eq($sformatf("fair_rsp_sat_%0d", i), 32'(rsp_sat), 32'(exp_sat[g]));
    end

    // Backpressure: response for requester 2 held while requester 3 waits
    rv = 4'b0100;
    #1;
    check_eq("bp_grant2", 32'(req_ready), 32'h4);
    tick();
    rd[3] = 24'h000000;
    rv = 4'b1000;
    rsp_ready = 1'b0;
    tick();
    for (int j = 0; j < 5; j++) begin
      check_eq($sformatf("bp_ready_%0d", j), 32'(req_ready), 32'h0);
      check_eq($sformatf("bp_valid_%0d", j), 32'(rsp_valid), 32'h1);
      check_eq($sformatf("bp_id_%0d", j), 32'(rsp_id), 32'h2);
      check_eq($sformatf("bp_data_%0d", j), 32'(rsp_data), 32'h200000);
      check_eq($sformatf("bp_sat_%0d", j), 32'(rsp_sat), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_release_grant3", 32'(req_ready), 32'h8);
    tick();
    rv = 4'h0;
    check_eq("bp_exec_busy", 32'(busy), 32'h1);
    check_eq("bp_exec_valid", 32'(rsp_valid), 32'h0);
    check_eq("bp_rec_data3", 32'(rec_op), 32'h0);

    // Saturation on zero operand
    tick();
    check_eq("sat_valid", 32'(rsp_valid), 32'h1);
    check_eq("sat_id", 32'(rsp_id), 32'h3);
    check_eq("sat_flag", 32'(rsp_sat), 32'h1);
    check_eq("sat_data", 32'(rsp_data), 32'hFFFFFF);
    tick();
    check_eq("sat_idle", 32'(busy), 32'h0);

    // Reset during EXEC: pointer last=3, so requester 1 wins here
    rv = 4'b0010;
    #1;
    check_eq("rexec_grant1", 32'(req_ready), 32'h2);
    tick();
    check_eq("rexec_in_exec", 32'(busy), 32'h1);
    rv = 4'h0;
    reset = 1'b1;
    tick();
    check_eq("rexec_valid", 32'(rsp_valid), 32'h0);
    check_eq("rexec_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    rv = 4'hF;
    #1;
    check_eq("rexec_next_grant0", 32'(req_ready), 32'h1);
    tick();
    rv = 4'h0;
    check_eq("rexec_post_valid", 32'(rsp_valid), 32'h0);
    tick();
    check_eq("rexec_post_id", 32'(rsp_id), 32'h0);

    // Reset wins over a simultaneous RESP handshake and new request
    rv = 4'hF;
    reset = 1'b1;
    tick();
    check_eq("rwin_valid", 32'(rsp_valid), 32'h0);
    check_eq("rwin_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    rv = 4'h0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
